// File: rtl/adc_pwm_mirror.sv
// Paces ADC conversion requests, averages 2^AVG_LOG2 samples per channel and
// drives one glitch-free PWM output per channel from the averaged value.
module adc_pwm_mirror #(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int SAMPLE_RATE_HZ = 100_000,
    parameter int NUM_CHANNELS   = 2,
    parameter int SAMPLE_WIDTH   = 12,
    parameter int AVG_LOG2       = 2,
    parameter int PWM_WIDTH      = 12
) (
    input  logic                                 clk_i,
    input  logic                                 rst,
    input  logic                                 enable_i,
    output logic                                 request_o,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] data_i,
    input  logic                                 data_valid_i,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] avg_o,
    output logic                                 avg_valid_o,
    output logic                                 overrun_o,
    output logic [NUM_CHANNELS-1:0]              pwm_o
);

    localparam int DIVIDER = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
    localparam int TW      = $clog2(DIVIDER);
    localparam int AW      = SAMPLE_WIDTH + AVG_LOG2;
    localparam int CW      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [TW-1:0] TMAX     = TW'(DIVIDER - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    function automatic logic [SAMPLE_WIDTH-1:0] avg_trunc(input logic [AW-1:0] s);
        return SAMPLE_WIDTH'(s >> AVG_LOG2);
    endfunction

    logic [TW-1:0]        timer;
    logic                 pending;
    logic                 tick;
    logic                 last;
    logic [CW-1:0]        cnt;
    logic [AW-1:0]        acc    [NUM_CHANNELS];
    logic [AW-1:0]        sum_p0 [NUM_CHANNELS];
    logic [PWM_WIDTH-1:0] pcnt;
    logic [PWM_WIDTH-1:0] shadow [NUM_CHANNELS];
    logic [PWM_WIDTH-1:0] active [NUM_CHANNELS];

    assign tick = enable_i && (timer == TMAX);
    assign last = (cnt == CNT_LAST);

    // Request pacing: a tick with a request still outstanding is an overrun.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            timer     <= '0;
            pending   <= 1'b0;
            request_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            request_o <= tick && !pending;
            if (tick && pending)
                overrun_o <= 1'b1;
            if (!enable_i || timer == TMAX)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (tick && !pending)
                pending <= 1'b1;
            else if (data_valid_i)
                pending <= 1'b0;
        end
    end

    // Stage p0: running sum including the incoming sample.
    always_comb begin
        for (int k = 0; k < NUM_CHANNELS; k++)
            sum_p0[k] = acc[k] + AW'(data_i[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            cnt         <= '0;
            avg_valid_o <= 1'b0;
            avg_o       <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++)
                acc[k] <= '0;
        end else begin
            avg_valid_o <= enable_i && data_valid_i && last;
            if (!enable_i) begin
                cnt <= '0;
                for (int k = 0; k < NUM_CHANNELS; k++)
                    acc[k] <= '0;
            end else if (data_valid_i) begin
                if (last) begin
                    cnt <= '0;
                    for (int k = 0; k < NUM_CHANNELS; k++) begin
                        acc[k] <= '0;
                        avg_o[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= avg_trunc(sum_p0[k]);
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    for (int k = 0; k < NUM_CHANNELS; k++)
                        acc[k] <= sum_p0[k];
                end
            end
        end
    end

    // PWM: compares only change at the period boundary so no cycle is truncated.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            pcnt  <= '0;
            pwm_o <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            pcnt <= pcnt + 1'b1;
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (avg_valid_o)
                    shadow[k] <= avg_o[k*SAMPLE_WIDTH + SAMPLE_WIDTH - 1 -: PWM_WIDTH];
                if (pcnt == '1)
                    active[k] <= shadow[k];
                pwm_o[k] <= (pcnt < active[k]);
            end
        end
    end

endmodule

// File: doc/adc_pwm_mirror.md
Name: adc_pwm_mirror

Overview:
Parametrised N-channel successor to the two-channel PMOD AD1 sample-to-PWM path. It paces ADC conversions with an internal sample-rate timer and averages 2^AVG_LOG2 samples per channel. Each averaged value drives a glitch-free PWM output whose duty cycle updates only at period boundaries. It sits between an ADC serial interface (request/data/valid) and board pins, and replaces the per-design sample registers and loose PWM instances.

Parameters:
CLK_FREQ_HZ, 100_000_000, clk_i frequency.
SAMPLE_RATE_HZ, 100_000, request rate; DIVIDER = CLK_FREQ_HZ/SAMPLE_RATE_HZ, must be >= 2.
NUM_CHANNELS, 2, number of ADC channels / PWM outputs, >= 1.
SAMPLE_WIDTH, 12, bits per channel sample.
AVG_LOG2, 2, samples averaged = 2^AVG_LOG2; 0 = passthrough.
PWM_WIDTH, 12, PWM resolution, <= SAMPLE_WIDTH; uses average MSBs.

Ports:
clk_i  in  1  clock
rst  in  1  reset: synchronous, active-high; clock clk_i
enable_i  in  1  run enable, already synchronous to clk_i
request_o  out  1  one-cycle conversion request to ADC interface
data_i  in  NUM_CHANNELS*SAMPLE_WIDTH  packed samples; channel k at [k*SW +: SW]
data_valid_i  in  1  one-cycle strobe, data_i valid
avg_o  out  NUM_CHANNELS*SAMPLE_WIDTH  latest averages, same packing
avg_valid_o  out  1  one-cycle strobe, avg_o updated
overrun_o  out  1  sticky: tick occurred while a request was outstanding
pwm_o  out  NUM_CHANNELS  PWM outputs, registered

Behaviour:
- Reset: all outputs 0, timer 0, pending 0, accumulators/count 0, PWM counter 0, shadow and active compares 0.
- Timer counts 0..DIVIDER-1 while enable_i=1. Wrap (count==DIVIDER-1) = tick. With enable_i=0 the timer is forced to 0 and no ticks occur.
- On a tick with pending=0: request_o=1 for exactly that cycle (registered, asserted the cycle after the counter reaches DIVIDER-1), and pending is set.
- On a tick with pending=1: no request, overrun_o set. overrun_o clears only on rst.
- data_valid_i clears pending.
  - Accepted only if enable_i=1; otherwise discarded. Accumulator unchanged.
  - If data_valid_i and a tick coincide while pending=1: the valid clears pending, the tick issues no request and sets overrun.
- Accumulator per channel is SAMPLE_WIDTH+AVG_LOG2 bits, unsigned, no saturation needed. Sample count is AVG_LOG2 bits.
- On an accepted valid with count < 2^AVG_LOG2-1: acc += sample; count++.
- On an accepted valid with count == 2^AVG_LOG2-1: avg = (acc+sample)>>AVG_LOG2 (truncate); acc, count cleared. avg_o and avg_valid_o are registered next cycle (latency 1 from data_valid_i).
- AVG_LOG2=0: every accepted valid produces avg = sample, latency 1.
- enable_i low for >=1 cycle clears acc and count; partial averages are discarded. avg_o and PWM compares hold their values.
- PWM counter: free-running PWM_WIDTH bits, wraps 2^PWM_WIDTH-1 -> 0, runs regardless of enable_i.
- On avg_valid_o: shadow[k] = avg[k][SW-1 -: PWM_WIDTH].
- Active compare loads from shadow only in the cycle the counter == 2^PWM_WIDTH-1. A new duty cycle therefore first applies to the period starting at counter 0; there are no mid-period glitches.
- pwm_o[k] registered: 1 when counter < active[k].
  - compare 0: constantly low.
  - compare 2^PW-1: low exactly 1 cycle per period.
- rst mid-operation: everything returns to reset values next cycle. An in-flight ADC response after reset is accepted as normal if enable_i=1 (pending is already 0).

Test Plan:
1. CLK_FREQ_HZ=1000, SAMPLE_RATE_HZ=100, enable_i=1, no data -> request_o pulses once at cycle 10 after reset release. No further requests; at the next tick overrun_o=1 and stays 1.
2. AVG_LOG2=2, ch0 samples 100,101,102,105 with valids after each request -> one avg_valid_o, 1 cycle after the 4th valid, ch0 avg=102. No avg_valid_o after valids 1-3.
3. AVG_LOG2=0, SW=PW=4, avg 4'd5 delivered mid-period -> pwm_o[0] unchanged until counter wraps. Then high for exactly 5 of 16 cycles per period. Compare 0 -> constantly low; compare 15 -> low 1 cycle per period.
4. enable_i dropped after 2 of 4 samples, then restored -> no requests while low. Valid during low is ignored. After re-enable, 4 fresh samples are needed for the next average, equal to their own mean.
5. data_valid_i coincident with a tick while pending -> no request that cycle, overrun_o=1, pending=0. Request issued on the following tick.
6. rst asserted mid-accumulation with pwm active -> next cycle all outputs 0, overrun_o=0, and the first average after release uses only post-reset samples.
